// File: rtl/approx_product_error_monitor.sv
// Error-statistics monitor for the approximate multiplier: compares exact and
// approximate products over a fixed-length run and holds the results until acknowledged.
module approx_product_error_monitor #(
    parameter int PW        = 64,
    parameter int N_SAMPLES = 256,
    parameter int CNT_W     = 16,
    parameter int ACC_W     = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    exact_p,
    input  logic [PW-1:0]    approx_p,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] err_sum,
    output logic [PW-1:0]    err_max,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] over_count
);

    localparam int SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             clear_stats;

    logic             vld_p1;
    logic [PW-1:0]    diff_p1;
    logic             nz_p1;
    logic             over_p1;

    logic [ACC_W-1:0] err_sum_q;
    logic [PW-1:0]    err_max_q;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] over_count_q;

    function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Clamps at all-ones instead of wrapping when the carry out is set.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc, input logic [PW-1:0] d);
        logic [SUM_W-1:0] s;
        s = {1'b0, acc} + SUM_W'(d);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign accept      = in_valid && in_ready;
    assign clear_stats = (state_q == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = (cnt_q < N_CNT);
                if (in_ready && in_valid && (cnt_q == N_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!vld_p1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Stage 1: absolute difference and per-pair flags, captured on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            diff_p1 <= abs_diff(exact_p, approx_p);
            nz_p1   <= (exact_p != approx_p);
            over_p1 <= (approx_p > exact_p);
        end
    end

    // Stage 2: fold the registered difference into the run statistics.
    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            err_sum_q    <= '0;
            err_max_q    <= '0;
            err_count_q  <= '0;
            over_count_q <= '0;
        end else if (vld_p1) begin
            err_sum_q    <= sat_add(err_sum_q, diff_p1);
            err_max_q    <= (diff_p1 > err_max_q) ? diff_p1 : err_max_q;
            err_count_q  <= err_count_q + CNT_W'(nz_p1);
            over_count_q <= over_count_q + CNT_W'(over_p1);
        end
    end

    assign err_sum    = err_sum_q;
    assign err_max    = err_max_q;
    assign err_count  = err_count_q;
    assign over_count = over_count_q;

endmodule

// File: tb/tb_approx_product_error_monitor.sv
// Directed self-checking bench: a 4-sample monitor for the functional tests and a
// 2-sample, 64-bit-accumulator monitor for the saturation boundary.
module tb_approx_product_error_monitor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: N_SAMPLES=4, ACC_W=80
    logic        start, in_valid, in_ready, busy, out_valid, out_ready;
    logic [63:0] exact_p, approx_p, err_max;
    logic [79:0] err_sum;
    logic [15:0] err_count, over_count;

    // Saturation instance: N_SAMPLES=2, ACC_W=64
    logic        s_start, s_in_valid, s_in_ready, s_busy, s_out_valid, s_out_ready;
    logic [63:0] s_exact_p, s_approx_p, s_err_max, s_err_sum;
    logic [15:0] s_err_count, s_over_count;

    approx_product_error_monitor #(.PW(64), .N_SAMPLES(4), .CNT_W(16), .ACC_W(80)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .exact_p(exact_p), .approx_p(approx_p), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .err_sum(err_sum), .err_max(err_max),
        .err_count(err_count), .over_count(over_count));

    approx_product_error_monitor #(.PW(64), .N_SAMPLES(2), .CNT_W(16), .ACC_W(64)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .exact_p(s_exact_p), .approx_p(s_approx_p), .busy(s_busy), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .err_sum(s_err_sum), .err_max(s_err_max),
        .err_count(s_err_count), .over_count(s_over_count));

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;

    always @(posedge clk) begin
        if (in_valid && in_ready) acc_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit sel);
        if (sel) s_start = 1'b1; else start = 1'b1;
        tick();
        s_start = 1'b0;
        start   = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [63:0] e, input logic [63:0] a, input int gap);
        int bound;
        repeat (gap) tick();
        if (sel) begin
            s_exact_p = e; s_approx_p = a; s_in_valid = 1'b1;
        end else begin
            exact_p = e; approx_p = a; in_valid = 1'b1;
        end
        bound = 0;
        while (!(sel ? s_in_ready : in_ready) && bound < 50) begin
            tick();
            bound++;
        end
        if (bound >= 50) chk("send_timeout", 1'b0, 1'b1);
        tick();
        s_in_valid = 1'b0;
        in_valid   = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int bound;
        bound = 0;
        while (!(sel ? s_out_valid : out_valid) && bound < 50) begin
            tick();
            bound++;
        end
        chk("done_reached", (sel ? s_out_valid : out_valid), 1'b1);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ack_idle_ov", out_valid, 1'b0);
        chk("ack_idle_busy", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start = 0; in_valid = 0; out_ready = 0; exact_p = 0; approx_p = 0;
        s_start = 0; s_in_valid = 0; s_out_ready = 0; s_exact_p = 0; s_approx_p = 0;
        tick();
        tick();
        rst = 1'b0;

        // Idle with in_valid held and no start
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("idle_in_ready", in_ready, 1'b0);
            chk("idle_out_valid", out_valid, 1'b0);
            chk("idle_stats", {err_sum, err_max, err_count, over_count}, '0);
            tick();
        end
        in_valid = 1'b0;
        chk("idle_no_accepts", acc_cnt, 0);

        // Exact run with latency check
        do_start(0);
        chk("run_busy", busy, 1'b1);
        chk("run_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) send(0, 64'd100, 64'd100, 0);
        chk("lat0_ov", out_valid, 1'b0);
        chk("lat0_in_ready", in_ready, 1'b0);
        chk("lat0_busy", busy, 1'b1);
        tick();
        chk("lat1_ov", out_valid, 1'b0);
        tick();
        chk("lat2_ov", out_valid, 1'b1);
        chk("exact_sum", err_sum, 80'd0);
        chk("exact_max", err_max, 64'd0);
        chk("exact_cnt", err_count, 16'd0);
        chk("exact_over", over_count, 16'd0);
        ack();

        // Mixed errors
        do_start(0);
        send(0, 64'd100, 64'd90, 0);
        send(0, 64'd100, 64'd115, 0);
        send(0, 64'd50, 64'd50, 0);
        send(0, 64'd7, 64'd0, 0);
        wait_done(0);
        chk("mix_sum", err_sum, 80'd32);
        chk("mix_max", err_max, 64'd15);
        chk("mix_cnt", err_count, 16'd3);
        chk("mix_over", over_count, 16'd1);
        ack();

        // Gaps between pairs, then backpressure on the results
        acc_cnt = 0;
        do_start(0);
        send(0, 64'd1000, 64'd1003, 0);
        send(0, 64'd20, 64'd20, 2);
        send(0, 64'd5, 64'd9, 1);
        send(0, 64'd0, 64'd1, 3);
        in_valid = 1'b1;
        exact_p = 64'd999; approx_p = 64'd0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready_low", in_ready, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepts", acc_cnt, 4);
        wait_done(0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_ov", out_valid, 1'b1);
            chk("bp_hold_sum", err_sum, 80'd8);
            tick();
        end
        chk("bp_max", err_max, 64'd4);
        chk("bp_cnt", err_count, 16'd3);
        chk("bp_over", over_count, 16'd3);
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        chk("done_start_ignored_busy", busy, 1'b0);
        chk("done_start_ignored_ov", out_valid, 1'b0);
        tick();
        chk("idle_keep_sum", err_sum, 80'd8);
        chk("idle_keep_cnt", err_count, 16'd3);

        // Saturation on the 64-bit accumulator instance
        do_start(1);
        send(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        send(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        wait_done(1);
        chk("sat_sum", s_err_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sat_max", s_err_max, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sat_cnt", s_err_count, 16'd2);
        chk("sat_over", s_over_count, 16'd0);

        // Reset in the middle of a run with a pair in flight
        do_start(0);
        send(0, 64'd10, 64'd8, 0);
        send(0, 64'd10, 64'd8, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_stats", {err_sum, err_max, err_count, over_count}, '0);
        tick();
        chk("rst_stats_after", {err_sum, err_max, err_count, over_count}, '0);
        do_start(0);
        for (int i = 0; i < 4; i++) send(0, 64'd10, 64'd8, 0);
        wait_done(0);
        chk("post_rst_sum", err_sum, 80'd8);
        chk("post_rst_max", err_max, 64'd2);
        chk("post_rst_cnt", err_count, 16'd4);
        chk("post_rst_over", over_count, 16'd0);
        ack();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
